// File: rtl/hbif_pkg.sv
// Shared constants and state encoding for the host-bus-interface responder.
package hbif_pkg;

  localparam int DATA_W = 8;

  // Command bytes that open a frame
  localparam logic [DATA_W-1:0] CMD_WR = 8'h57;
  localparam logic [DATA_W-1:0] CMD_RD = 8'h52;

  // Response bytes returned to the host
  localparam logic [DATA_W-1:0] RSP_OK  = 8'h4B;
  localparam logic [DATA_W-1:0] RSP_ERR = 8'h3F;
  localparam logic [DATA_W-1:0] RSP_TMO = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } hbif_state_e;

endpackage

// File: rtl/hbif_timer.sv
// Saturating cycle counter. Counts while start_i is high and flags the
// LIMIT-th counted cycle, so the owner can leave its state on that cycle.
module hbif_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAX_C  = CW'(LIMIT);
  localparam logic [CW-1:0] LAST_C = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;

  // Count elapsed cycles, holding at LIMIT instead of wrapping
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (start_i && (count_q != MAX_C)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = start_i && (count_q >= LAST_C);

endmodule

// File: rtl/hbif_responder.sv
// Target end of the host byte protocol: decodes 'W'/'R' frames from the UART
// receiver, runs one register-bus transaction and returns a one-byte response.
module hbif_responder
  import hbif_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT = 275000,
  parameter int unsigned BUS_TIMEOUT   = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              tx_ready_i,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [DATA_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              busy_o,
  output logic              overrun_o
);

  hbif_state_e       state_q, state_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic              ovr_q, ovr_d;
  logic              in_frame, in_bus;
  logic              frame_exp, bus_exp;

  assign in_frame = (state_q == ADDR) || (state_q == DATA);
  assign in_bus   = (state_q == BUS);

  // Inter-byte timer: reloads on every byte taken mid-frame, idle elsewhere
  hbif_timer #(.LIMIT(FRAME_TIMEOUT)) u_frame_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (in_frame),
    .clear_i   (!in_frame || rx_valid_i),
    .expired_o (frame_exp)
  );

  // Bus watchdog: counts request cycles without an acknowledge
  hbif_timer #(.LIMIT(BUS_TIMEOUT)) u_bus_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (in_bus),
    .clear_i   (!in_bus),
    .expired_o (bus_exp)
  );

  // State and frame-field registers; reset clears every visible output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame decode and transaction sequencing; ack beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsp_d   = rsp_q;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid_i && en_i) begin
          if ((rx_data_i == CMD_WR) || (rx_data_i == CMD_RD)) begin
            we_d    = (rx_data_i == CMD_WR);
            state_d = ADDR;
          end else begin
            rsp_d   = RSP_ERR;
            state_d = RESP;
          end
        end
      end
      ADDR: begin
        if (rx_valid_i) begin
          addr_d  = rx_data_i;
          state_d = we_q ? DATA : BUS;
        end else if (frame_exp) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (rx_valid_i) begin
          wdata_d = rx_data_i;
          state_d = BUS;
        end else if (frame_exp) begin
          state_d = IDLE;
        end
      end
      BUS: begin
        ovr_d = rx_valid_i;
        if (bus_ack_i) begin
          rsp_d   = we_q ? RSP_OK : bus_rdata_i;
          state_d = RESP;
        end else if (bus_exp) begin
          rsp_d   = RSP_TMO;
          state_d = RESP;
        end
      end
      RESP: begin
        ovr_d = rx_valid_i;
        if (tx_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_valid_o  = (state_q == RESP);
  assign tx_data_o   = rsp_q;
  assign bus_req_o   = in_bus;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign busy_o      = (state_q != IDLE);
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_hbif_responder.sv
// Scoreboard bench for hbif_responder: stimulus pushes expected bus
// transactions and response bytes, independent monitors pop and compare.
module tb_hbif_responder;

  localparam int FT = 40;
  localparam int BT = 12;

  logic       clk = 1'b0;
  logic       rst, en, rx_valid, tx_ready, tx_valid;
  logic [7:0] rx_data, tx_data;
  logic       bus_req, bus_we, bus_ack, busy, overrun;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  hbif_responder #(.FRAME_TIMEOUT(FT), .BUS_TIMEOUT(BT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .tx_ready_i  (tx_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_rdata_i (bus_rdata),
    .bus_ack_i   (bus_ack),
    .busy_o      (busy),
    .overrun_o   (overrun)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         chk_wdata;
    int         len;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  logic [7:0] rd_val = 8'h00;
  int ready_mode = 0;
  int late_ack_cnt = 0;
  int ovr_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register-bus target: acks ack_delay cycles into a request, else noise
  initial begin : bus_drv
    int age;
    int late_done;
    age = 0;
    late_done = 0;
    bus_ack = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      bus_rdata = 8'($urandom);
      if (bus_req) begin
        if (age == ack_delay) begin
          bus_ack = 1'b1;
          bus_rdata = rd_val;
        end
        age++;
      end else begin
        age = 0;
        if (late_done != late_ack_cnt) begin
          bus_ack = 1'b1;
          late_done++;
        end
      end
    end
  end

  // Transmitter: always ready, randomly ready, or stalled
  initial begin : ready_drv
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: response bytes, bus transactions and overrun pulses
  initial begin : mon
    bus_t cur;
    bit   cur_ok;
    int   len;
    logic prev_req;
    logic prev_hold;
    logic [7:0] held;
    cur_ok = 0; len = 0; prev_req = 0; prev_hold = 0; held = 8'h00;
    forever begin
      @(negedge clk);
      if (overrun) ovr_seen++;
      if (tx_valid) begin
        if (prev_hold) check("tx_data_stable", tx_data, held);
        if (tx_ready) begin
          if (exp_tx.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected: got %0h expected no response", tx_data);
          end else begin
            check("tx_data", tx_data, exp_tx.pop_front());
          end
          prev_hold = 0;
        end else begin
          prev_hold = 1;
          held = tx_data;
        end
      end else begin
        prev_hold = 0;
      end
      if (bus_req && !prev_req) begin
        len = 1;
        if (exp_bus.size() == 0) begin
          cur_ok = 0;
          checks++; failures++;
          $display("FAIL bus_unexpected: got req addr=%0h expected no request", bus_addr);
        end else begin
          cur = exp_bus.pop_front();
          cur_ok = 1;
        end
      end else if (bus_req) begin
        len++;
      end else if (prev_req && cur_ok) begin
        check("bus_req_len", len, cur.len);
      end
      if (bus_req && cur_ok) begin
        check("bus_we", bus_we, cur.we);
        check("bus_addr", bus_addr, cur.addr);
        if (cur.chk_wdata) check("bus_wdata", bus_wdata, cur.wdata);
      end
      prev_req = bus_req;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick(1);
      n++;
    end
    check("idle_reached", busy, 1'b0);
    tick(2);
  endtask

  // Reference model: what one complete frame must produce on bus and tx
  task automatic expect_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d,
                              input int dly, input logic [7:0] rdat, output int nb);
    bus_t e;
    ack_delay = dly;
    rd_val = rdat;
    if (cmd == 8'h57 || cmd == 8'h52) begin
      e.we = (cmd == 8'h57);
      e.addr = a;
      e.wdata = d;
      e.chk_wdata = e.we;
      e.len = (dly < BT) ? dly + 1 : BT;
      exp_bus.push_back(e);
      if (dly >= BT)  exp_tx.push_back(8'hEE);
      else if (e.we)  exp_tx.push_back(8'h4B);
      else            exp_tx.push_back(rdat);
      nb = e.we ? 3 : 2;
    end else begin
      exp_tx.push_back(8'h3F);
      nb = 1;
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d,
                           input int dly, input logic [7:0] rdat, input int gmax);
    int nb;
    expect_frame(cmd, a, d, dly, rdat, nb);
    for (int i = 0; i < nb; i++) begin
      tick(int'($urandom_range(gmax, 0)));
      if (i > 0) en = 1'($urandom);
      send_byte(i == 0 ? cmd : (i == 1 ? a : d));
    end
    en = 1'b1;
    wait_idle();
  endtask

  initial begin : stim
    int nb;
    int ovr0;
    logic [7:0] c;
    bus_t e;
    rst = 1'b1; en = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    tick(3);
    rst = 1'b0;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_bus_addr", bus_addr, 8'h00);
    tick(2);

    // Write with ack 3 cycles after request
    ready_mode = 0;
    run_frame(8'h57, 8'h10, 8'hA5, 3, 8'h00, 0);

    // Read with immediate ack, response stalled for 5 cycles
    ready_mode = 2;
    expect_frame(8'h52, 8'h22, 8'h00, 0, 8'h3C, nb);
    send_byte(8'h52);
    send_byte(8'h22);
    check("rd_req_after_addr", bus_req, 1'b1);
    check("rd_no_tx_yet", tx_valid, 1'b0);
    tick(1);
    check("rd_tx_latency", tx_valid, 1'b1);
    check("rd_tx_data", tx_data, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("rd_hold_valid", tx_valid, 1'b1);
      check("rd_hold_data", tx_data, 8'h3C);
    end
    ready_mode = 0;
    wait_idle();

    // Unknown command, then a command while disabled
    run_frame(8'h41, 8'h00, 8'h00, 0, 8'h00, 0);
    en = 1'b0;
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) begin
      check("disabled_busy", busy, 1'b0);
      tick(1);
    end
    en = 1'b1;

    // Bus timeout then a stray ack while idle
    run_frame(8'h57, 8'h33, 8'h77, 1000, 8'h00, 1);
    late_ack_cnt++;
    tick(3);
    check("late_ack_busy", busy, 1'b0);
    check("late_ack_tx", tx_valid, 1'b0);

    // Ack on the last allowed cycle wins; one cycle later times out
    run_frame(8'h52, 8'h44, 8'h00, BT - 1, 8'h99, 0);
    run_frame(8'h57, 8'h45, 8'h12, BT, 8'h00, 0);

    // Abandoned frame, then a normal read
    send_byte(8'h57);
    send_byte(8'h10);
    tick(FT + 3);
    check("frame_tmo_busy", busy, 1'b0);
    check("frame_tmo_tx", tx_valid, 1'b0);
    run_frame(8'h52, 8'h10, 8'h00, 1, 8'h5A, 2);

    // Slow but in-time bytes complete the frame
    expect_frame(8'h57, 8'h11, 8'h22, 2, 8'h00, nb);
    send_byte(8'h57);
    tick(FT - 5);
    send_byte(8'h11);
    tick(FT - 5);
    send_byte(8'h22);
    wait_idle();

    // Byte arriving during BUS is dropped with one overrun pulse
    ovr0 = ovr_seen;
    expect_frame(8'h57, 8'h60, 8'h61, 6, 8'h00, nb);
    send_byte(8'h57);
    send_byte(8'h60);
    send_byte(8'h61);
    tick(2);
    send_byte(8'hAA);
    wait_idle();
    check("overrun_pulses", ovr_seen - ovr0, 1);

    // Reset while the response is waiting aborts it
    ready_mode = 2;
    ack_delay = 0;
    rd_val = 8'h77;
    e.we = 1'b0; e.addr = 8'h70; e.wdata = 8'h00; e.chk_wdata = 0; e.len = 1;
    exp_bus.push_back(e);
    send_byte(8'h52);
    send_byte(8'h70);
    tick(1);
    check("pre_rst_tx_valid", tx_valid, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("post_rst_tx_valid", tx_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    ready_mode = 0;
    tick(2);

    // Randomized frames with random gaps, enable and transmitter stalls
    ready_mode = 1;
    for (int k = 0; k < 40; k++) begin
      int kind;
      int dly;
      kind = int'($urandom_range(4, 0));
      dly = ($urandom_range(7, 0) == 0) ? BT + 3 : int'($urandom_range(4, 0));
      if (kind < 2)      c = 8'h57;
      else if (kind < 4) c = 8'h52;
      else begin
        c = 8'($urandom);
        while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
      end
      run_frame(c, 8'($urandom), 8'($urandom), dly, 8'($urandom), 3);
    end

    tick(5);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("bus_queue_drained", exp_bus.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
